// File: rtl/sva_thread_scheduler_if.sv
// Evaluator handshake bundle for sva_thread_scheduler.
//
// Handshake: the master raises eval_req with eval_state/eval_start and holds
// all three stable until it samples eval_ack high on a rising edge. A request
// is consumed on every cycle where eval_req && eval_ack. The slave may raise
// eval_ack combinationally in the same cycle eval_req rises. eval_next_state,
// eval_keep, eval_succ and eval_fail are only meaningful while eval_ack is high.
//
// Signals:
//   eval_req         master->slave  request valid
//   eval_state       master->slave  encoded state of the thread under evaluation
//   eval_start       master->slave  start timestamp of that thread
//   eval_ack         slave->master  result valid
//   eval_next_state  slave->master  state the thread advances to
//   eval_keep        slave->master  thread stays live
//   eval_succ        slave->master  thread completed successfully
//   eval_fail        slave->master  thread failed
interface sva_thread_scheduler_if #(
  parameter int STATE_W = 8,
  parameter int TS_W    = 8
);
  logic               eval_req;
  logic [STATE_W-1:0] eval_state;
  logic [TS_W-1:0]    eval_start;
  logic               eval_ack;
  logic [STATE_W-1:0] eval_next_state;
  logic               eval_keep;
  logic               eval_succ;
  logic               eval_fail;

  modport master (
    output eval_req, eval_state, eval_start,
    input  eval_ack, eval_next_state, eval_keep, eval_succ, eval_fail
  );

  modport slave (
    input  eval_req, eval_state, eval_start,
    output eval_ack, eval_next_state, eval_keep, eval_succ, eval_fail
  );
endinterface

// File: rtl/sva_thread_scheduler.sv
// Time-shares one combinational SVA next-state evaluator across up to
// NUM_SLOTS live assertion threads. Each tick sweeps every live thread
// through the evaluator in slot order, compacting survivors in place, then
// spawns one new thread from INIT_STATE stamped with the current tick count.
//
// Ports:
//   sys_clk, sys_rst_n  clock, asynchronous active-low reset
//   tick                one-cycle pulse per user-clock rising edge
//   grst                synchronous user reset (level), beats tick and ack
//   ev                  evaluator handshake (master side)
//   busy                sweep in progress
//   active_cnt          live threads after the last sweep
//   tick_cnt            wrapping tick counter / spawn timestamp source
//   succ_cnt, fail_cnt  saturating result counters
//   overflow            sticky: a spawn was dropped with the pool full
//   tick_miss           sticky: a tick arrived during a sweep
//   dbg_state           FSM state (0 idle, 1 scan, 2 spawn)
//   dbg_valid           per-slot valid bits
module sva_thread_scheduler #(
  parameter int                 NUM_SLOTS  = 4,
  parameter int                 STATE_W    = 8,
  parameter int                 TS_W       = 8,
  parameter logic [STATE_W-1:0] INIT_STATE = '0,
  parameter int                 CNT_W      = 16,
  localparam int                AW         = $clog2(NUM_SLOTS + 1)
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   tick,
  input  logic                   grst,
  sva_thread_scheduler_if.master ev,
  output logic                   busy,
  output logic [AW-1:0]          active_cnt,
  output logic [TS_W-1:0]        tick_cnt,
  output logic [CNT_W-1:0]       succ_cnt,
  output logic [CNT_W-1:0]       fail_cnt,
  output logic                   overflow,
  output logic                   tick_miss,
  output logic [1:0]             dbg_state,
  output logic [NUM_SLOTS-1:0]   dbg_valid
);

  // Array index width; counts need one more value (0..NUM_SLOTS) than indices.
  localparam int            IW      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [AW-1:0] SLOTS_L = AW'(NUM_SLOTS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_SPAWN = 2'd2
  } state_e;

  state_e               state_q;
  logic [NUM_SLOTS-1:0] valid_q;
  logic [STATE_W-1:0]   st_q [NUM_SLOTS];
  logic [TS_W-1:0]      ts_q [NUM_SLOTS];
  logic [AW-1:0]        snap_q, rd_idx_q, wr_idx_q, active_q;
  logic [TS_W-1:0]      tick_cnt_q, spawn_ts_q;
  logic [CNT_W-1:0]     succ_q, fail_q;
  logic                 ovf_q, miss_q;

  logic [IW-1:0]        rd_ptr, wr_ptr;
  logic [AW-1:0]        rd_nxt, wr_fin;
  logic                 spawn_store;
  logic                 ack_fire;

  assign rd_ptr   = rd_idx_q[IW-1:0];
  assign wr_ptr   = wr_idx_q[IW-1:0];
  assign ack_fire = ev.eval_req && ev.eval_ack;

  always_comb begin
    rd_nxt      = rd_idx_q + AW'(1);
    spawn_store = (state_q == S_SPAWN) && ev.eval_ack && ev.eval_keep &&
                  (wr_idx_q < SLOTS_L);
    wr_fin      = wr_idx_q + (spawn_store ? AW'(1) : AW'(0));
  end

  // Evaluator request decode. The spawn timestamp is latched when the sweep
  // starts so it stays stable even if a (missed) tick bumps tick_cnt mid-sweep.
  always_comb begin
    ev.eval_req   = 1'b0;
    ev.eval_state = st_q[rd_ptr];
    ev.eval_start = ts_q[rd_ptr];
    if (state_q == S_SCAN && rd_idx_q != snap_q) begin
      ev.eval_req = 1'b1;
    end
    if (state_q == S_SPAWN) begin
      ev.eval_req   = 1'b1;
      ev.eval_state = INIT_STATE;
      ev.eval_start = spawn_ts_q;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      snap_q     <= '0;
      rd_idx_q   <= '0;
      wr_idx_q   <= '0;
      active_q   <= '0;
      tick_cnt_q <= '0;
      spawn_ts_q <= '0;
      succ_q     <= '0;
      fail_q     <= '0;
      ovf_q      <= 1'b0;
      miss_q     <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        st_q[i] <= '0;
        ts_q[i] <= '0;
      end
    end else if (grst) begin
      // Any sweep in flight is abandoned; slot payloads are dead once invalid.
      state_q    <= S_IDLE;
      valid_q    <= '0;
      snap_q     <= '0;
      rd_idx_q   <= '0;
      wr_idx_q   <= '0;
      active_q   <= '0;
      tick_cnt_q <= '0;
      spawn_ts_q <= '0;
      succ_q     <= '0;
      fail_q     <= '0;
      ovf_q      <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      if (tick) begin
        tick_cnt_q <= tick_cnt_q + TS_W'(1);
        if (state_q != S_IDLE) miss_q <= 1'b1;
      end
      if (ack_fire && ev.eval_succ && succ_q != '1) succ_q <= succ_q + CNT_W'(1);
      if (ack_fire && ev.eval_fail && fail_q != '1) fail_q <= fail_q + CNT_W'(1);

      unique case (state_q)
        S_IDLE: begin
          if (tick) begin
            snap_q     <= active_q;
            rd_idx_q   <= '0;
            wr_idx_q   <= '0;
            spawn_ts_q <= tick_cnt_q + TS_W'(1);
            state_q    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (rd_idx_q == snap_q) begin
            state_q <= S_SPAWN;
          end else if (ev.eval_ack) begin
            // wr_idx never passes rd_idx, so the write lands on a slot already read.
            if (ev.eval_keep) begin
              st_q[wr_ptr]    <= ev.eval_next_state;
              ts_q[wr_ptr]    <= ts_q[rd_ptr];
              valid_q[wr_ptr] <= 1'b1;
              wr_idx_q        <= wr_idx_q + AW'(1);
            end
            rd_idx_q <= rd_nxt;
            // Go straight to SPAWN after the last live thread: no idle scan cycle.
            if (rd_nxt == snap_q) state_q <= S_SPAWN;
          end
        end
        S_SPAWN: begin
          if (ev.eval_ack) begin
            if (spawn_store) begin
              st_q[wr_ptr] <= ev.eval_next_state;
              ts_q[wr_ptr] <= spawn_ts_q;
            end else if (ev.eval_keep) begin
              ovf_q <= 1'b1;
            end
            for (int i = 0; i < NUM_SLOTS; i++) begin
              valid_q[i] <= (AW'(i) < wr_fin);
            end
            wr_idx_q <= wr_fin;
            active_q <= wr_fin;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign active_cnt = active_q;
  assign tick_cnt   = tick_cnt_q;
  assign succ_cnt   = succ_q;
  assign fail_cnt   = fail_q;
  assign overflow   = ovf_q;
  assign tick_miss  = miss_q;
  assign dbg_state  = state_q;
  assign dbg_valid  = valid_q;

endmodule

// File: tb/tb_sva_thread_scheduler.sv
// Bench for sva_thread_scheduler: directed tick/response sequences, a
// thread-list model checked every cycle, and literal expectations per scenario.
module tb_sva_thread_scheduler;
  localparam int NS = 4;
  localparam int SW = 8;
  localparam int TW = 8;
  localparam int CW = 4;
  localparam int AW = 3;
  localparam logic [SW-1:0] INIT = 8'h00;
  localparam int CNT_MAX = (1 << CW) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic tick = 1'b0;
  logic grst = 1'b0;
  logic busy, overflow, tick_miss;
  logic [AW-1:0] active_cnt;
  logic [TW-1:0] tick_cnt;
  logic [CW-1:0] succ_cnt, fail_cnt;
  logic [1:0] dbg_state;
  logic [NS-1:0] dbg_valid;

  always #5 sys_clk = ~sys_clk;

  sva_thread_scheduler_if #(.STATE_W(SW), .TS_W(TW)) ev_if ();

  sva_thread_scheduler #(
    .NUM_SLOTS(NS), .STATE_W(SW), .TS_W(TW), .INIT_STATE(INIT), .CNT_W(CW)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tick(tick), .grst(grst),
    .ev(ev_if), .busy(busy), .active_cnt(active_cnt), .tick_cnt(tick_cnt),
    .succ_cnt(succ_cnt), .fail_cnt(fail_cnt), .overflow(overflow),
    .tick_miss(tick_miss), .dbg_state(dbg_state), .dbg_valid(dbg_valid)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- evaluator responder ----------------
  typedef struct {
    int          delay;
    logic [SW-1:0] ns;
    bit          keep;
    bit          succ;
    bit          fail;
  } resp_t;

  resp_t resp_q[$];
  resp_t cur_r;
  int    wait_cnt = 0;
  bit    ack_given = 0;

  task automatic push_resp(input int d, input logic [SW-1:0] ns, input bit k, input bit s, input bit f);
    resp_t r;
    r.delay = d; r.ns = ns; r.keep = k; r.succ = s; r.fail = f;
    resp_q.push_back(r);
  endtask

  // Queued responses are used in order; with none queued the evaluator
  // answers at once with state+1 and keep=1.
  initial begin
    ev_if.eval_ack = 1'b0;
    ev_if.eval_next_state = '0;
    ev_if.eval_keep = 1'b0;
    ev_if.eval_succ = 1'b0;
    ev_if.eval_fail = 1'b0;
    forever begin
      @(posedge sys_clk); #1;
      if (ack_given) begin
        if (resp_q.size() > 0) void'(resp_q.pop_front());
        wait_cnt = 0;
      end
      ack_given = 0;
      ev_if.eval_ack = 1'b0;
      ev_if.eval_keep = 1'b0;
      ev_if.eval_succ = 1'b0;
      ev_if.eval_fail = 1'b0;
      if (ev_if.eval_req) begin
        if (resp_q.size() > 0) cur_r = resp_q[0];
        else begin
          cur_r.delay = 0; cur_r.ns = ev_if.eval_state + 8'd1;
          cur_r.keep = 1; cur_r.succ = 0; cur_r.fail = 0;
        end
        if (wait_cnt < cur_r.delay) wait_cnt++;
        else begin
          ev_if.eval_ack = 1'b1;
          ev_if.eval_next_state = cur_r.ns;
          ev_if.eval_keep = cur_r.keep;
          ev_if.eval_succ = cur_r.succ;
          ev_if.eval_fail = cur_r.fail;
          ack_given = 1;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  typedef struct packed {
    logic [SW-1:0] st;
    logic [TW-1:0] ts;
  } thr_t;

  thr_t mq[$];   // live threads, oldest first
  thr_t nq[$];   // survivors being collected during a sweep
  thr_t xq[$];   // requests still expected in this sweep (spawn is last)
  bit   m_busy, m_dead, m_ovf, m_miss;
  int   m_tick, m_active, m_succ, m_fail;

  task model_clear();
    mq.delete(); nq.delete(); xq.delete();
    m_busy = 0; m_dead = 0; m_ovf = 0; m_miss = 0;
    m_tick = 0; m_active = 0; m_succ = 0; m_fail = 0;
  endtask

  initial begin
    thr_t t;
    bit   was_busy;
    bit   exp_req;
    model_clear();
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        model_clear();
        continue;
      end
      exp_req = m_busy && !m_dead;
      check("busy", 32'(busy), 32'(m_busy));
      check("eval_req", 32'(ev_if.eval_req), 32'(exp_req));
      if (exp_req && xq.size() > 0) begin
        check("eval_state", 32'(ev_if.eval_state), 32'(xq[0].st));
        check("eval_start", 32'(ev_if.eval_start), 32'(xq[0].ts));
      end
      check("active_cnt", 32'(active_cnt), 32'(m_active));
      check("tick_cnt", 32'(tick_cnt), 32'(m_tick));
      check("succ_cnt", 32'(succ_cnt), 32'(m_succ));
      check("fail_cnt", 32'(fail_cnt), 32'(m_fail));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("tick_miss", 32'(tick_miss), 32'(m_miss));
      check("slot_valid", 32'(dbg_valid), (32'd1 << m_active) - 32'd1);

      // advance to what the coming edge must produce
      if (grst) begin
        model_clear();
      end else begin
        was_busy = m_busy;
        if (was_busy) begin
          if (m_dead) m_dead = 0;
          else if (exp_req && ev_if.eval_ack && xq.size() > 0) begin
            t = xq.pop_front();
            if (ev_if.eval_succ && m_succ < CNT_MAX) m_succ++;
            if (ev_if.eval_fail && m_fail < CNT_MAX) m_fail++;
            if (ev_if.eval_keep) begin
              t.st = ev_if.eval_next_state;
              if (xq.size() == 0 && nq.size() >= NS) m_ovf = 1;
              else nq.push_back(t);
            end
            if (xq.size() == 0) begin
              mq = nq;
              m_active = mq.size();
              m_busy = 0;
            end
          end
        end
        if (tick) begin
          m_tick = (m_tick + 1) % (1 << TW);
          if (was_busy) m_miss = 1;
          else begin
            xq = mq;
            t.st = INIT; t.ts = TW'(m_tick);
            xq.push_back(t);
            nq.delete();
            m_busy = 1;
            m_dead = (mq.size() == 0);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_tick();
    @(posedge sys_clk); #1 tick = 1'b1;
    @(posedge sys_clk); #1 tick = 1'b0;
  endtask

  task automatic pulse_grst();
    @(posedge sys_clk); #1 grst = 1'b1;
    @(posedge sys_clk); #1 grst = 1'b0;
  endtask

  // Counts busy cycles seen at negedges until busy drops (bounded).
  task automatic wait_idle(output int cyc);
    bit timed_out;
    cyc = 0;
    timed_out = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      if (!busy) begin
        timed_out = 0;
        break;
      end
      cyc++;
    end
    check("idle_timeout", 32'(timed_out), 32'd0);
  endtask

  task automatic tick_and_wait(output int cyc);
    send_tick();
    wait_idle(cyc);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int cyc;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;

    // reset state
    @(negedge sys_clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req", 32'(ev_if.eval_req), 32'd0);
    check("rst_active", 32'(active_cnt), 32'd0);
    check("rst_tick_cnt", 32'(tick_cnt), 32'd0);
    check("rst_succ", 32'(succ_cnt), 32'd0);
    check("rst_fail", 32'(fail_cnt), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_tick_miss", 32'(tick_miss), 32'd0);
    check("rst_dbg_state", 32'(dbg_state), 32'd0);

    // single spawn from an empty pool
    push_resp(0, 8'h05, 1, 0, 0);
    tick_and_wait(cyc);
    check("s1_busy_cycles", 32'(cyc), 32'd2);
    check("s1_active", 32'(active_cnt), 32'd1);
    check("s1_tick_cnt", 32'(tick_cnt), 32'd1);

    // fill the pool; the stored thread must come back as state 5, start 1
    send_tick();
    @(negedge sys_clk);
    check("s2_first_req", 32'(ev_if.eval_req), 32'd1);
    check("s2_slot0_state", 32'(ev_if.eval_state), 32'h05);
    check("s2_slot0_start", 32'(ev_if.eval_start), 32'd1);
    wait_idle(cyc);
    tick_and_wait(cyc);
    tick_and_wait(cyc);
    check("s2_active_full", 32'(active_cnt), 32'd4);
    check("s2_no_overflow_yet", 32'(overflow), 32'd0);
    tick_and_wait(cyc);
    check("s2_busy_cycles_n4", 32'(cyc), 32'd5);
    check("s2_overflow", 32'(overflow), 32'd1);
    check("s2_active_sat", 32'(active_cnt), 32'd4);
    tick_and_wait(cyc);
    check("s2_active_sat6", 32'(active_cnt), 32'd4);
    check("s2_tick_miss", 32'(tick_miss), 32'd0);
    check("s2_tick_cnt", 32'(tick_cnt), 32'd6);

    // compaction: 3 threads, keep pattern 0,1,0 then spawn kept
    pulse_grst();
    @(negedge sys_clk);
    check("s3_grst_active", 32'(active_cnt), 32'd0);
    check("s3_grst_overflow", 32'(overflow), 32'd0);
    repeat (3) tick_and_wait(cyc);
    push_resp(0, 8'h11, 0, 0, 0);
    push_resp(0, 8'h22, 1, 0, 0);
    push_resp(0, 8'h33, 0, 0, 0);
    push_resp(0, 8'h44, 1, 0, 0);
    tick_and_wait(cyc);
    check("s3_active", 32'(active_cnt), 32'd2);
    send_tick();
    @(negedge sys_clk);
    check("s3_slot0_state", 32'(ev_if.eval_state), 32'h22);
    check("s3_slot0_start", 32'(ev_if.eval_start), 32'd2);
    @(negedge sys_clk);
    check("s3_slot1_state", 32'(ev_if.eval_state), 32'h44);
    check("s3_slot1_start", 32'(ev_if.eval_start), 32'd4);
    wait_idle(cyc);

    // slow evaluator: 3 wait cycles per request, 2 live threads
    pulse_grst();
    repeat (2) tick_and_wait(cyc);
    push_resp(3, 8'h70, 1, 0, 0);
    push_resp(3, 8'h71, 1, 0, 0);
    push_resp(3, 8'h72, 1, 0, 0);
    tick_and_wait(cyc);
    check("s4_busy_cycles", 32'(cyc), 32'd12);
    check("s4_active", 32'(active_cnt), 32'd3);

    // tick during a sweep is flagged but still counted
    send_tick();
    send_tick();
    wait_idle(cyc);
    check("s4_tick_miss", 32'(tick_miss), 32'd1);
    check("s4_tick_cnt", 32'(tick_cnt), 32'd5);
    check("s4_active_after", 32'(active_cnt), 32'd4);

    // counter saturation
    pulse_grst();
    for (int i = 0; i < CNT_MAX; i++) begin
      push_resp(0, 8'h00, 0, 0, 1);
      tick_and_wait(cyc);
    end
    check("s5_fail_sat", 32'(fail_cnt), 32'hF);
    check("s5_succ_zero", 32'(succ_cnt), 32'd0);
    push_resp(0, 8'h00, 0, 1, 1);
    tick_and_wait(cyc);
    check("s5_fail_held", 32'(fail_cnt), 32'hF);
    check("s5_succ_inc", 32'(succ_cnt), 32'd1);
    check("s5_active", 32'(active_cnt), 32'd0);

    // grst mid-SCAN with a simultaneous tick
    pulse_grst();
    repeat (2) tick_and_wait(cyc);
    push_resp(5, 8'h90, 1, 1, 0);
    push_resp(5, 8'h91, 1, 1, 0);
    push_resp(5, 8'h92, 1, 1, 0);
    send_tick();
    @(posedge sys_clk); #1;
    grst = 1'b1;
    tick = 1'b1;
    @(posedge sys_clk); #1;
    grst = 1'b0;
    tick = 1'b0;
    resp_q.delete();
    @(negedge sys_clk);
    check("s6_busy", 32'(busy), 32'd0);
    check("s6_req", 32'(ev_if.eval_req), 32'd0);
    check("s6_active", 32'(active_cnt), 32'd0);
    check("s6_tick_cnt", 32'(tick_cnt), 32'd0);
    check("s6_succ", 32'(succ_cnt), 32'd0);
    check("s6_fail", 32'(fail_cnt), 32'd0);
    check("s6_tick_miss", 32'(tick_miss), 32'd0);
    tick_and_wait(cyc);
    check("s6_recover_active", 32'(active_cnt), 32'd1);
    check("s6_recover_busy", 32'(cyc), 32'd2);

    repeat (3) @(posedge sys_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sva_thread_scheduler.md
Name: sva_thread_scheduler

Overview:
- Time-shares one combinational SVA next-state evaluator across up to NUM_SLOTS concurrently live assertion threads.
- On every user-clock tick it sweeps all live threads through the evaluator in order and compacts the survivors in place. It then spawns one new thread from INIT_STATE.
- It sits between the gclk edge detector (source of tick) and the per-property evaluator; it replaces the hard-wired single-thread control loop.

Parameters:
- NUM_SLOTS, 4, maximum live threads; must be ≥1.
- STATE_W, 8, width of the encoded property state.
- TS_W, 8, width of the tick timestamp; wraps modulo 2^TS_W.
- INIT_STATE, 0, state loaded into each newly spawned thread.
- CNT_W, 16, width of the succ/fail counters.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle pulse per user-clock rising edge, already synchronous to sys_clk.
- grst  in  1  user reset; synchronous clear, level-sensitive.
- eval_req  out  1  evaluator request.
- eval_state  out  STATE_W  current state of the thread being evaluated.
- eval_start  out  TS_W  start timestamp of the thread being evaluated.
- eval_ack  in  1  evaluator result valid; may be asserted in the same cycle as eval_req.
- eval_next_state  in  STATE_W  next state.
- eval_keep  in  1  thread stays live.
- eval_succ  in  1  thread completed successfully.
- eval_fail  in  1  thread failed.
- busy  out  1  sweep in progress.
- active_cnt  out  $clog2(NUM_SLOTS+1)  live threads after the last sweep.
- tick_cnt  out  TS_W  tick counter, used as the spawn timestamp.
- succ_cnt  out  CNT_W  saturating success count.
- fail_cnt  out  CNT_W  saturating failure count.
- overflow  out  1  sticky: a spawn was dropped because the pool was full.
- tick_miss  out  1  sticky: tick arrived while busy.

Behaviour:
- Reset (sys_rst_n=0) and grst=1 clear identically:
  - all slots invalid; FSM to IDLE;
  - eval_req, busy, overflow and tick_miss are 0;
  - active_cnt, tick_cnt, succ_cnt and fail_cnt are 0.
- grst takes priority over tick and eval_ack in the same cycle. A sweep in progress is aborted and its results are discarded.
- Slot storage: valid, state[STATE_W] and start[TS_W] per slot. Live slots are always packed at indices 0..active_cnt-1.
- tick_cnt increments (wrapping) on every tick, in any FSM state.
- FSM:
  - IDLE: on tick, set snap=active_cnt, rd_idx=0, wr_idx=0, and go to SCAN.
    - Further ticks in SCAN or SPAWN are ignored for sweeping and set tick_miss.
  - SCAN:
    - If rd_idx==snap, go to SPAWN.
    - Otherwise drive eval_req=1 with eval_state/eval_start from slot[rd_idx]; hold both stable until eval_ack.
    - On ack: if eval_keep, write {eval_next_state, original start} to slot[wr_idx] and increment wr_idx. Always increment rd_idx.
    - In-place compaction is safe because wr_idx ≤ rd_idx.
  - SPAWN:
    - Drive eval_req=1 with eval_state=INIT_STATE and eval_start=tick_cnt (the value after the triggering tick).
    - On ack with eval_keep: if wr_idx<NUM_SLOTS, store the thread and increment wr_idx; otherwise drop it and set overflow.
    - On ack: invalidate slots ≥ wr_idx, set active_cnt=wr_idx, go to IDLE.
- busy = (state != IDLE). eval_req is 0 in IDLE.
- Latency with eval_ack tied high and N live threads:
  - the transition to SCAN is registered on the tick edge;
  - busy is high for exactly N+1 cycles (N SCAN cycles, 1 SPAWN cycle).
  - Each cycle of eval_ack low adds one cycle.
- Counters: each ack with eval_succ increments succ_cnt; each ack with eval_fail increments fail_cnt. Both increment if both are asserted. Both saturate at all-ones.
- eval_succ/eval_fail/eval_keep are ignored unless eval_ack && eval_req.
- N=0 at tick: SCAN falls through to SPAWN on the first cycle without asserting eval_req. busy lasts 2 cycles.

Test Plan:
- Reset, then 1 tick with ack=1, keep=1, next_state=5 → busy high 2 cycles; active_cnt=1; slot0 state=5, start=1; tick_cnt=1.
- NUM_SLOTS=4, keep=1 always, 6 ticks → active_cnt saturates at 4; overflow=1 after tick 5; tick_miss=0 when ticks are spaced ≥6 cycles.
- 3 live threads, evaluator returns keep=0,1,0 for slots 0,1,2 and keep=1 for spawn → active_cnt=2; slot0 holds old slot1 state and start; slot1 holds the new thread.
- eval_ack delayed 3 cycles per request with 2 live threads → eval_req and eval_state held stable during waits; busy high 3×3+3=12 cycles.
- Drive fail and succ on one ack, with fail_cnt preloaded to 0xFFFF → fail_cnt stays 0xFFFF; succ_cnt increments by 1.
- Assert grst mid-SCAN with 2 live threads → next cycle busy=0, eval_req=0, active_cnt=0, all counters 0; a tick asserted in the same cycle as grst is ignored.
